// File: rtl/cfg_bitstream_loader_if.sv
// Stream and configuration-write bundle for the bitstream loader.
// The master side supplies the framed configuration stream and observes
// the fabric write port; the slave side is the loader.
interface cfg_bitstream_loader_if #(
  parameter int ADDR_W = 6
);
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_ready;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [31:0]       cfg_wdata;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  cfg_we,
    input  cfg_addr,
    input  cfg_wdata
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output cfg_we,
    output cfg_addr,
    output cfg_wdata
  );
endinterface

// File: rtl/cfg_bitstream_loader.sv
// Configuration bitstream loader for the fpga fabric.
// Accepts a framed image (header, NUM_WORDS payload words, XOR trailer),
// writes each payload word into the fabric configuration map one cycle
// after it is accepted, and only enables fabric user logic once the whole
// image has been written and its checksum matches.
module cfg_bitstream_loader #(
  parameter int          NUM_WORDS = 57,
  parameter int          ADDR_W    = 6,
  parameter logic [15:0] MAGIC     = 16'hCF60
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  cfg_bitstream_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  fabric_en
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // Index of the final payload word; the counter stops here instead of wrapping.
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_WORDS - 1);
  // Word count the header must announce in its low half.
  localparam logic [15:0]       WORD_COUNT = 16'(NUM_WORDS);

  state_t            state;
  logic [ADDR_W-1:0] counter;
  logic [31:0]       checksum;
  logic              accept;
  logic              header_ok;

  // A beat only moves when the loader has advertised ready from registered state.
  assign accept    = bus.s_valid & bus.s_ready;
  assign header_ok = (bus.s_data[31:16] == MAGIC) && (bus.s_data[15:0] == WORD_COUNT);

  // Load sequencer: all handshake, write-port and status outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      counter       <= '0;
      checksum      <= '0;
      bus.s_ready   <= 1'b0;
      bus.cfg_we    <= 1'b0;
      bus.cfg_addr  <= '0;
      bus.cfg_wdata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      fabric_en     <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse unless a payload word is taken.
      bus.cfg_we <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state       <= S_HEADER;
            counter     <= '0;
            checksum    <= '0;
            bus.s_ready <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            fabric_en   <= 1'b0;
          end
        end

        S_HEADER: begin
          if (accept) begin
            if (header_ok) begin
              state <= S_LOAD;
            end else begin
              state       <= S_ERROR;
              bus.s_ready <= 1'b0;
              busy        <= 1'b0;
              error       <= 1'b1;
              fabric_en   <= 1'b0;
            end
          end
        end

        S_LOAD: begin
          if (accept) begin
            checksum      <= checksum ^ bus.s_data;
            bus.cfg_we    <= 1'b1;
            bus.cfg_addr  <= counter;
            bus.cfg_wdata <= bus.s_data;
            if (counter == LAST_ADDR) begin
              state <= S_CHECK;
            end else begin
              counter <= counter + ADDR_W'(1);
            end
          end
        end

        S_CHECK: begin
          if (accept) begin
            bus.s_ready <= 1'b0;
            busy        <= 1'b0;
            if (bus.s_data == checksum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              fabric_en <= 1'b1;
            end else begin
              state     <= S_ERROR;
              error     <= 1'b1;
              fabric_en <= 1'b0;
            end
          end
        end

        default: begin
          state       <= S_IDLE;
          bus.s_ready <= 1'b0;
          busy        <= 1'b0;
          fabric_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Directed testbench for cfg_bitstream_loader.
// Drives framed images through the stream interface and checks the write
// port and status flags against hand-derived expectations.
module tb_cfg_bitstream_loader;

  localparam int NUM_WORDS = 57;
  localparam int ADDR_W    = 6;

  logic clock;
  logic reset;
  logic start;
  logic busy;
  logic done;
  logic error;
  logic fabric_en;

  int checks;
  int failures;
  int write_count;

  cfg_bitstream_loader_if #(.ADDR_W(ADDR_W)) bus ();

  cfg_bitstream_loader #(
    .NUM_WORDS(NUM_WORDS),
    .ADDR_W   (ADDR_W),
    .MAGIC    (16'hCF60)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bus      (bus.slave),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .fabric_en(fabric_en)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] payload(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every fabric write must land on the next index in order with its payload word.
  always @(negedge clock) begin
    if (bus.cfg_we === 1'b1) begin
      check_output("wr_addr", 32'(bus.cfg_addr), 32'(write_count));
      check_output("wr_data", bus.cfg_wdata, payload(write_count));
      write_count++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_data  = 32'hBAD0_BAD0;
    tick(n);
  endtask

  task automatic apply_reset();
    bus.s_valid = 1'b0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [31:0] d);
    bit acc;
    int budget;
    acc    = 1'b0;
    budget = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (!acc && budget < 100) begin
      acc = bus.s_ready;
      @(posedge clock);
      #1;
      budget++;
    end
    if (!acc) check_output("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_start();
    bus.s_valid = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_output("start_busy", 32'(busy), 32'd1);
    check_output("start_ready", 32'(bus.s_ready), 32'd1);
    check_output("start_done", 32'(done), 32'd0);
    check_output("start_error", 32'(error), 32'd0);
    check_output("start_fabric_en", 32'(fabric_en), 32'd0);
  endtask

  task automatic load_image(input bit stalls, input bit bad_trailer,
                            input int start_word, input int abort_word);
    logic [31:0] sum;
    sum = '0;
    write_count = 0;
    do_start();
    apply_stimulus(32'hCF60_0039);
    if (stalls) idle(1);
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (i == start_word) start = 1'b1;
      apply_stimulus(payload(i));
      start = 1'b0;
      sum = sum ^ payload(i);
      if (i == abort_word) return;
      if (stalls) begin
        idle(1);
        if (i == 30) idle(20);
      end
    end
    check_output("pre_trailer_busy", 32'(busy), 32'd1);
    check_output("pre_trailer_done", 32'(done), 32'd0);
    apply_stimulus(bad_trailer ? (sum ^ 32'd1) : sum);
    bus.s_valid = 1'b0;
  endtask

  task automatic check_good_end(input string tag);
    check_output({tag, "_done"}, 32'(done), 32'd1);
    check_output({tag, "_fabric_en"}, 32'(fabric_en), 32'd1);
    check_output({tag, "_error"}, 32'(error), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_ready"}, 32'(bus.s_ready), 32'd0);
    check_output({tag, "_writes"}, 32'(write_count), 32'd57);
  endtask

  task automatic check_bad_header(input string tag);
    check_output({tag, "_error"}, 32'(error), 32'd1);
    check_output({tag, "_ready"}, 32'(bus.s_ready), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_fabric_en"}, 32'(fabric_en), 32'd0);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h1234_5678;
    tick(3);
    bus.s_valid = 1'b0;
    check_output({tag, "_ready_after"}, 32'(bus.s_ready), 32'd0);
    check_output({tag, "_writes"}, 32'(write_count), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Directed sequence covering reset, good, bad, stalled and interrupted loads.
  initial begin
    checks      = 0;
    failures    = 0;
    write_count = 0;
    reset       = 1'b1;
    start       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    tick(2);
    reset = 1'b0;

    $display("[TB] reset state");
    check_output("rst_ready", 32'(bus.s_ready), 32'd0);
    check_output("rst_we", 32'(bus.cfg_we), 32'd0);
    check_output("rst_addr", 32'(bus.cfg_addr), 32'd0);
    check_output("rst_wdata", bus.cfg_wdata, 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_error", 32'(error), 32'd0);
    check_output("rst_fabric_en", 32'(fabric_en), 32'd0);

    $display("[TB] good image back-to-back");
    load_image(1'b0, 1'b0, -1, -1);
    check_good_end("good");
    idle(3);
    check_output("good_done_sticky", 32'(done), 32'd1);
    check_output("good_addr_hold", 32'(bus.cfg_addr), 32'd56);

    $display("[TB] restart from DONE with start pulsed during load");
    load_image(1'b0, 1'b0, 10, -1);
    check_good_end("restart");

    $display("[TB] bad header word count");
    write_count = 0;
    do_start();
    apply_stimulus(32'hCF60_0038);
    bus.s_valid = 1'b0;
    check_bad_header("hdr_count");

    $display("[TB] bad header magic");
    write_count = 0;
    do_start();
    apply_stimulus(32'hDEAD_0039);
    bus.s_valid = 1'b0;
    check_bad_header("hdr_magic");

    $display("[TB] bad checksum");
    load_image(1'b0, 1'b1, -1, -1);
    check_output("csum_error", 32'(error), 32'd1);
    check_output("csum_done", 32'(done), 32'd0);
    check_output("csum_fabric_en", 32'(fabric_en), 32'd0);
    check_output("csum_writes", 32'(write_count), 32'd57);
    idle(2);
    check_output("csum_fabric_en_hold", 32'(fabric_en), 32'd0);

    $display("[TB] stalled image");
    load_image(1'b1, 1'b0, -1, -1);
    check_good_end("stall");

    $display("[TB] reset mid-load");
    load_image(1'b0, 1'b0, -1, 20);
    apply_reset();
    check_output("midrst_writes", 32'(write_count), 32'd21);
    check_output("midrst_we", 32'(bus.cfg_we), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_done", 32'(done), 32'd0);
    check_output("midrst_error", 32'(error), 32'd0);
    check_output("midrst_ready", 32'(bus.s_ready), 32'd0);
    check_output("midrst_addr", 32'(bus.cfg_addr), 32'd0);
    bus.s_valid = 1'b1;
    bus.s_data  = payload(21);
    tick(5);
    bus.s_valid = 1'b0;
    check_output("midrst_no_writes", 32'(write_count), 32'd21);
    load_image(1'b0, 1'b0, -1, -1);
    check_good_end("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfg_bitstream_loader.md
Name: cfg_bitstream_loader

Overview:
- Upstream configuration stage for the fpga fabric. It receives a framed configuration stream over a valid/ready word interface and writes each payload word into the fabric's switch-block and LUT configuration storage through an addressed write port. This replaces hierarchical pokes at simulation time.
- Checks a header and an XOR checksum trailer.
- Holds the fabric's user logic disabled until a complete, verified image has been written.

Parameters:
- NUM_WORDS, 57, payload words per image (fabric configuration map: s1..s13 configure, l1..l22 mem low/high words).
- ADDR_W, 6, width of cfg_addr; must satisfy 2^ADDR_W >= NUM_WORDS.
- MAGIC, 16'hCF60, required value of header bits [31:16].

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load.
- s_valid  in  1  stream word valid.
- s_data  in  32  stream word.
- s_ready  out  1  loader can accept a word this cycle.
- cfg_we  out  1  one-cycle write strobe to the fabric configuration map.
- cfg_addr  out  ADDR_W  configuration word index, 0..NUM_WORDS-1.
- cfg_wdata  out  32  configuration word; the fabric uses bit 0 only for LUT mem[32] entries.
- busy  out  1  a load is in progress.
- done  out  1  sticky; image loaded and verified.
- error  out  1  sticky; header or checksum failure.
- fabric_en  out  1  enables fabric user logic; high only when done.

Behaviour:
- The clock is named clock. Reset is synchronous and active-high. All state and outputs are registered.
- Reset values: state IDLE, s_ready=0, cfg_we=0, cfg_addr=0, cfg_wdata=0, busy=0, done=0, error=0, fabric_en=0, word counter=0, checksum=0.
- A beat is accepted when s_valid && s_ready. s_ready depends only on registered state, never on s_valid. s_data is ignored when no beat is accepted.
- IDLE: s_ready=0.
  - start -> HEADER. Sets busy=1. Clears done, error and fabric_en. Clears the counter and checksum.
- HEADER: s_ready=1.
  - On accept, s_data[31:16]==MAGIC and s_data[15:0]==NUM_WORDS -> LOAD.
  - Otherwise -> ERROR.
- LOAD: s_ready=1.
  - Each accepted word: checksum ^= s_data.
  - The next cycle drives cfg_we=1, cfg_addr=counter, cfg_wdata=word. Then the counter increments.
  - After the accept with counter==NUM_WORDS-1 -> CHECK.
  - cfg_we is high for exactly one cycle per payload word. Write latency is 1 cycle from accept.
- CHECK: s_ready=1.
  - The accepted word is compared with the accumulated checksum (XOR of all payload words).
  - Equal -> DONE. Otherwise -> ERROR.
- DONE: done=1, fabric_en=1, busy=0, s_ready=0. Both flags assert the cycle after the trailer is accepted.
- ERROR: error=1, fabric_en=0, busy=0, s_ready=0. Words already written stay in the fabric; fabric_en stays low.
- start restarts a load only from IDLE, DONE or ERROR. start while busy is ignored with no effect.
- Stalls: s_valid low holds all state. There is no timeout, and an indefinite stall is legal.
- With back-to-back valid, an image takes NUM_WORDS+2 accepted beats. The last cfg_we coincides with the trailer accept cycle.
- Reset mid-load: all outputs return to reset values on the next edge. No further cfg_we pulses follow, including any pending one. Fabric contents are not cleared.
- s_ready is low in the cycle the FSM leaves CHECK or HEADER to ERROR/DONE. No extra beat is consumed.
- The counter never exceeds NUM_WORDS-1 and does not wrap. cfg_addr holds the last written index between strobes.

Test Plan:
- Good image: start, then header 32'hCF60_0039, then words w[i]=32'h1000_0000+i for i=0..56, then trailer = XOR of all w[i], all back-to-back. Required: 57 cfg_we pulses with cfg_addr 0..56 in order and cfg_wdata=w[i]; done=1 and fabric_en=1 exactly 1 cycle after the trailer accept; error=0.
- Bad header: header 32'hCF60_0038 (count mismatch), then a separate run with header 32'hDEAD_0039. Required: ERROR the cycle after the header accept; zero cfg_we pulses; s_ready=0 afterwards; fabric_en=0.
- Bad checksum: the good image with the trailer bit 0 flipped. Required: all 57 writes occur; error=1 and done=0; fabric_en stays 0.
- Stalls: the good image with s_valid driven low on alternate cycles, plus a 20-cycle gap after word 30. Required: identical write sequence and done, with no duplicated or skipped addresses.
- Reset mid-load: reset asserted for 1 cycle right after word 20 is accepted. Required: no cfg_we after reset; busy, done and error all 0. A new start followed by a full good image then completes with done=1.
- start pulsed during LOAD at word 10: ignored, and the load completes normally. start in DONE re-enters HEADER, clearing done and fabric_en on the next edge.
